// File: rtl/axis_text_frame_buffer.sv
// axis_text_frame_buffer
// AXI4-Stream slave that assembles a character frame beat by beat into a
// shadow buffer and publishes it atomically on a line bus for the display.
// Malformed frames (early or missing tlast) are dropped and flagged.

module axis_text_frame_buffer #(
    parameter int LINE_CHARS = 16,
    parameter int NUM_LINES  = 4,
    parameter int BEAT_CHARS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [BEAT_CHARS*8-1:0]            s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    input  logic                               freeze,
    input  logic                               clear,
    output logic [NUM_LINES*LINE_CHARS*8-1:0]  lines_out,
    output logic                               frame_commit,
    output logic                               frame_err,
    output logic [7:0]                         frame_count
);

    localparam int BW  = BEAT_CHARS * 8;
    localparam int TOT = NUM_LINES * LINE_CHARS * 8;
    localparam int BPL = LINE_CHARS / BEAT_CHARS;
    localparam int BPF = BPL * NUM_LINES;
    localparam int KW  = (BPF > 1) ? $clog2(BPF) : 1;

    localparam logic [KW-1:0]  LAST_K = KW'(BPF - 1);
    localparam logic [TOT-1:0] SPACES = {(TOT/8){8'h20}};

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    logic [1:0]     state_r;
    logic [KW-1:0]  k_r;
    logic [TOT-1:0] shadow_r;
    logic [TOT-1:0] lines_r;
    logic           commit_r;
    logic           err_r;
    logic [7:0]     count_r;
    logic           tready_s;
    logic           xfer_s;

    // Ready depends only on registered state and the clear command.
    always_comb begin
        tready_s = 1'b0;
        if (clear) begin
            tready_s = 1'b0;
        end else begin
            case (state_r)
                ST_FILL:    tready_s = 1'b1;
                ST_DISCARD: tready_s = 1'b1;
                default:    tready_s = 1'b0;
            endcase
        end
    end

    assign xfer_s = s_axis_tvalid & tready_s;

    // Shadow buffer: beat k lands at global character k*BEAT_CHARS, line 0 at the MSB end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_r <= SPACES;
        end else if (xfer_s && (state_r == ST_FILL)) begin
            for (int b = 0; b < BPF; b++) begin
                if (k_r == KW'(b)) begin
                    shadow_r[TOT-1-b*BW -: BW] <= s_axis_tdata;
                end
            end
        end
    end

    // Frame FSM, beat index, display register, commit pulse, error flag and frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_FILL;
            k_r      <= '0;
            lines_r  <= SPACES;
            commit_r <= 1'b0;
            err_r    <= 1'b0;
            count_r  <= 8'd0;
        end else if (clear) begin
            state_r  <= ST_FILL;
            k_r      <= '0;
            lines_r  <= SPACES;
            commit_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            commit_r <= 1'b0;
            case (state_r)
                ST_FILL: begin
                    if (xfer_s) begin
                        if (k_r == LAST_K) begin
                            k_r <= '0;
                            if (s_axis_tlast) begin
                                state_r <= ST_COMMIT;
                            end else begin
                                err_r   <= 1'b1;
                                state_r <= ST_DISCARD;
                            end
                        end else if (s_axis_tlast) begin
                            err_r <= 1'b1;
                            k_r   <= '0;
                        end else begin
                            k_r <= k_r + KW'(1);
                        end
                    end
                end
                ST_DISCARD: begin
                    if (xfer_s && s_axis_tlast) begin
                        k_r     <= '0;
                        state_r <= ST_FILL;
                    end
                end
                ST_COMMIT: begin
                    if (freeze) begin
                        state_r <= ST_HOLD;
                    end else begin
                        lines_r  <= shadow_r;
                        commit_r <= 1'b1;
                        count_r  <= count_r + 8'd1;
                        k_r      <= '0;
                        state_r  <= ST_FILL;
                    end
                end
                ST_HOLD: begin
                    if (!freeze) begin
                        state_r <= ST_COMMIT;
                    end
                end
                default: begin
                    state_r <= ST_FILL;
                    k_r     <= '0;
                end
            endcase
        end
    end

    assign s_axis_tready = tready_s;
    assign lines_out     = lines_r;
    assign frame_commit  = commit_r;
    assign frame_err     = err_r;
    assign frame_count   = count_r;

endmodule

// File: tb/tb_axis_text_frame_buffer.sv
// Scoreboard bench for axis_text_frame_buffer: the driver feeds beats to a
// frame-length reference model that queues expected frames; a monitor pops
// and compares on every frame_commit.

module tb_axis_text_frame_buffer;

    localparam int LINE_CHARS = 16;
    localparam int NUM_LINES  = 4;
    localparam int BEAT_CHARS = 4;
    localparam int BW  = BEAT_CHARS * 8;
    localparam int TOT = NUM_LINES * LINE_CHARS * 8;
    localparam int BPF = (LINE_CHARS / BEAT_CHARS) * NUM_LINES;
    localparam logic [TOT-1:0] SPACES = {(TOT/8){8'h20}};

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [BW-1:0]  s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic           s_axis_tlast = 1'b0;
    logic           freeze = 1'b0;
    logic           clear = 1'b0;
    logic [TOT-1:0] lines_out;
    logic           frame_commit;
    logic           frame_err;
    logic [7:0]     frame_count;

    axis_text_frame_buffer #(
        .LINE_CHARS(LINE_CHARS), .NUM_LINES(NUM_LINES), .BEAT_CHARS(BEAT_CHARS)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .freeze(freeze), .clear(clear),
        .lines_out(lines_out), .frame_commit(frame_commit),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [BW-1:0]  m_beats[$];
    bit             m_discard = 1'b0;
    logic           m_err = 1'b0;
    logic [TOT-1:0] exp_frames[$];
    logic [7:0]     m_cnt = 8'd0;
    int             m_total = 0;
    logic [TOT-1:0] m_disp = SPACES;

    task automatic check(input string nm, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Frame model: a frame is good iff exactly BPF beats arrive with tlast on the last one.
    task automatic model_accept(input logic [BW-1:0] d, input logic last);
        logic [TOT-1:0] f;
        if (m_discard) begin
            if (last) m_discard = 1'b0;
        end else begin
            m_beats.push_back(d);
            if (m_beats.size() == BPF) begin
                if (last) begin
                    f = '0;
                    for (int i = 0; i < BPF; i++) f[TOT-1-i*BW -: BW] = m_beats[i];
                    exp_frames.push_back(f);
                end else begin
                    m_err = 1'b1;
                    m_discard = 1'b1;
                end
                m_beats.delete();
            end else if (last) begin
                m_err = 1'b1;
                m_beats.delete();
            end
        end
    endtask

    task automatic model_clear();
        m_beats.delete();
        m_discard = 1'b0;
        m_err = 1'b0;
        exp_frames.delete();
        m_disp = SPACES;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat transfers.
    task automatic send_beat(input logic [BW-1:0] d, input logic last, input bit rnd);
        int waited = 0;
        s_axis_tdata = d;
        s_axis_tlast = last;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            if (rnd) freeze = ($urandom_range(0, 3) == 0);
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL tready_timeout actual=0 expected=1");
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        if (rnd) freeze = ($urandom_range(0, 3) == 0);
        @(posedge clk);
        model_accept(d, last);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_idx, input bit rnd_data, input bit rnd);
        logic [BW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd_data ? BW'($urandom) : "ABCD";
            send_beat(d, i == last_idx, rnd);
            if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_frames.size() != 0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (exp_frames.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d expected=0", exp_frames.size());
        end
    endtask

    // Monitor: every commit must match the oldest expected frame and the next count.
    always @(negedge clk) begin
        if (reset && frame_commit) begin
            if (exp_frames.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_commit count=%0d", frame_count);
            end else begin
                m_disp = exp_frames.pop_front();
                m_cnt  = m_cnt + 8'd1;
                m_total++;
                check("commit_lines", lines_out, m_disp);
                check("commit_count", TOT'(frame_count), TOT'(m_cnt));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_lines", lines_out, SPACES);
        check("rst_commit", TOT'(frame_commit), '0);
        check("rst_err", TOT'(frame_err), '0);
        check("rst_count", TOT'(frame_count), '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_tready", TOT'(s_axis_tready), TOT'(1));
        @(posedge clk); #1;

        // Good "ABCD" frame; ready drops for exactly the commit cycle
        send_frame(BPF, BPF - 1, 1'b0, 1'b0);
        @(negedge clk);
        check("commit_tready", TOT'(s_axis_tready), '0);
        check("pre_commit", TOT'(frame_commit), '0);
        @(negedge clk);
        check("post_commit_tready", TOT'(s_axis_tready), TOT'(1));
        check("post_commit_pulse", TOT'(frame_commit), TOT'(1));
        @(posedge clk); #1;
        wait_drain();
        check("abcd_lines", lines_out, {(TOT/BW){32'h41424344}});
        check("abcd_count", TOT'(frame_count), TOT'(1));
        check("abcd_err", TOT'(frame_err), '0);

        // Early tlast on beat 5, then a good frame
        send_frame(6, 5, 1'b1, 1'b0);
        check("short_err", TOT'(frame_err), TOT'(m_err));
        repeat (3) begin @(posedge clk); #1; end
        check("short_lines", lines_out, m_disp);
        send_frame(BPF, BPF - 1, 1'b1, 1'b0);
        wait_drain();
        check("after_short_err", TOT'(frame_err), TOT'(m_err));
        check("after_short_count", TOT'(frame_count), TOT'(m_cnt));

        // Overlong frame: 20 beats, tlast on 19
        send_frame(20, 19, 1'b1, 1'b0);
        check("long_err", TOT'(frame_err), TOT'(m_err));
        repeat (3) begin @(posedge clk); #1; end
        send_frame(BPF, BPF - 1, 1'b1, 1'b0);
        wait_drain();
        check("after_long_count", TOT'(frame_count), TOT'(m_cnt));

        // Freeze mid-frame: held for 10 cycles, commit two edges after release
        send_frame(8, -1, 1'b1, 1'b0);
        freeze = 1'b1;
        send_frame(BPF - 8, BPF - 9, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_tready", TOT'(s_axis_tready), '0);
            check("hold_lines", lines_out, m_disp);
        end
        @(posedge clk); #1;
        freeze = 1'b0;
        @(negedge clk);
        check("unfreeze_e0", TOT'(frame_commit), '0);
        @(negedge clk);
        check("unfreeze_e1", TOT'(frame_commit), '0);
        @(negedge clk);
        check("unfreeze_e2", TOT'(frame_commit), TOT'(1));
        check("unfreeze_tready", TOT'(s_axis_tready), TOT'(1));
        @(posedge clk); #1;
        wait_drain();

        // Clear during HOLD with tvalid high
        freeze = 1'b1;
        send_frame(BPF, BPF - 1, 1'b1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        s_axis_tdata = 32'h5a5a5a5a;
        s_axis_tvalid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        check("clear_tready", TOT'(s_axis_tready), '0);
        @(posedge clk); #1;
        clear = 1'b0;
        s_axis_tvalid = 1'b0;
        model_clear();
        check("clear_lines", lines_out, SPACES);
        check("clear_err", TOT'(frame_err), '0);
        check("clear_count", TOT'(frame_count), TOT'(m_cnt));
        freeze = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("clear_no_commit_lines", lines_out, SPACES);

        // Random frames with random gaps and random freeze
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 5))
                0:       send_frame($urandom_range(1, BPF - 1), -2, 1'b1, 1'b1);
                1:       send_frame(BPF + $urandom_range(1, 5), -2, 1'b1, 1'b1);
                default: send_frame(BPF, BPF - 1, 1'b1, 1'b1);
            endcase
        end
        freeze = 1'b0;
        wait_drain();
        check("rand_err", TOT'(frame_err), TOT'(m_err));
        check("rand_count", TOT'(frame_count), TOT'(m_cnt));

        // Count wrap
        for (int f = 0; f < 300 && !(m_cnt == 8'd0 && m_total > 0); f++) begin
            send_frame(BPF, BPF - 1, 1'b1, 1'b0);
            wait_drain();
        end
        check("wrap_count", TOT'(frame_count), '0);
        check("wrap_model", TOT'(m_cnt), '0);

        // Asynchronous reset mid-frame
        send_frame(5, -1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_lines", lines_out, SPACES);
        check("arst_count", TOT'(frame_count), '0);
        check("arst_err", TOT'(frame_err), '0);
        check("arst_commit", TOT'(frame_commit), '0);
        model_clear();
        m_cnt = 8'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        send_frame(BPF, BPF - 1, 1'b1, 1'b0);
        wait_drain();
        check("post_arst_count", TOT'(frame_count), TOT'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_text_frame_buffer.md
# axis_text_frame_buffer

Parametrised AXI4-Stream slave that assembles a multi-line character frame beat by beat into a shadow buffer and commits it atomically to a display-facing line bus feeding `screen_oled`. The block adds real `tready` backpressure, `tlast` framing checks, a freeze/hold mode and a clear command. The display never shows a partially written frame.

## Interface
Parameters:
- `LINE_CHARS`, 16: characters per line. Must be a multiple of `BEAT_CHARS`.
- `NUM_LINES`, 4: lines per frame, at least 1.
- `BEAT_CHARS`, 4: characters per AXIS beat. `tdata` width is `BEAT_CHARS*8`.

Derived: `BPL = LINE_CHARS/BEAT_CHARS` (beats per line), `BPF = BPL*NUM_LINES` (beats per frame).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  BEAT_CHARS*8  characters. The MSB byte is the leftmost character.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  block can accept a beat.
- `s_axis_tlast`  in  1  last beat of the frame.
- `freeze`  in  1  level; hold the current display and defer commits.
- `clear`  in  1  synchronous command; blank the display and abort any frame in progress.
- `lines_out`  out  NUM_LINES*LINE_CHARS*8  display bus. Line 0 sits in the MSB slice; the leftmost character is the MSB byte of its slice.
- `frame_commit`  out  1  one-cycle pulse when `lines_out` updates.
- `frame_err`  out  1  sticky framing error; cleared only by `reset` or `clear`.
- `frame_count`  out  8  number of committed frames; wraps from 255 to 0.

## Operation
- Beat transfer occurs on `tvalid & tready` at a rising edge.
- Beat index `k` (0..BPF-1) writes line `k/BPL`, character slots `(k%BPL)*BEAT_CHARS` onward, into the shadow buffer.
- FSM states:
  - FILL: `tready`=1. Each accepted beat increments `k`.
    - Beat `k=BPF-1` with `tlast`=1 goes to COMMIT.
    - Beat `k=BPF-1` with `tlast`=0 sets `frame_err` and goes to DISCARD.
    - Beat `k<BPF-1` with `tlast`=1 sets `frame_err`, resets `k` to 0, stays in FILL, and drops the frame.
  - DISCARD: `tready`=1. Beats are accepted and dropped. A beat with `tlast`=1 resets `k` to 0 and goes to FILL.
  - COMMIT: `tready`=0.
    - If `freeze`=0: copy shadow to `lines_out`, pulse `frame_commit`, increment `frame_count`, go to FILL with `k`=0.
    - If `freeze`=1: go to HOLD.
  - HOLD: `tready`=0. The completed shadow frame is retained. When `freeze`=0, go to COMMIT.
- `freeze` while in FILL or DISCARD: reception continues. Only the commit is deferred, and the input is backpressured until `freeze` falls.
- `clear` sampled high at an edge:
  - `lines_out` is set to all 0x20 (space); `k`=0; state goes to FILL; `frame_err`=0; any HOLD frame is lost.
  - `frame_count` is unchanged.
  - `tready` is forced to 0 combinationally while `clear`=1, so no beat transfers in that cycle.
  - `clear` has priority over every other event.
- Shadow contents are not cleared between frames. Each new frame overwrites every slot.

## Timing
- Reset values (while `reset`=0 and after release):
  - `lines_out` all 0x20; `frame_commit`=0; `frame_err`=0; `frame_count`=0.
  - State FILL, `k`=0, so `s_axis_tready`=1 when `clear`=0.
- Last good beat accepted at edge E: state is COMMIT during cycle E..E+1 and `tready`=0.
- At edge E+1: `lines_out` updates, `frame_commit`=1 for exactly one cycle, `frame_count` increments, `tready` returns to 1.
- Latency from last beat to display is one edge. Sustained throughput is BPF beats per BPF+1 cycles.
- `freeze` is sampled in COMMIT and HOLD. When `freeze` falls, the commit edge is the second rising edge after the fall: one edge to HOLD→COMMIT, then the commit edge.
- `frame_err` rises at the edge that accepts the offending beat.
- `reset` assertion mid-frame takes effect immediately and asynchronously. The partial frame is lost.
- `tready` is a function of registered state plus `clear` only. It does not depend on `tvalid`.

## Test plan
- Reset, then send 16 beats (BPF=16 with defaults) of "ABCD" with `tlast` on beat 15 → `tready`=0 for one cycle, then `lines_out` is all "ABCD…", `frame_commit` pulses once, `frame_count`=1, `frame_err`=0.
- Send a frame with `tlast` on beat 5 → no commit, `frame_err`=1, `lines_out` unchanged. A following good frame commits, `frame_count` increments, and `frame_err` stays 1.
- Send 20 beats with `tlast` on beat 19 → beats 16..19 are dropped, `frame_err`=1, no commit. The next good frame commits normally.
- Assert `freeze` mid-frame and complete the frame → `tready` held at 0 and `lines_out` unchanged for 10 cycles. Deassert `freeze` → commit two edges later and `tready`=1.
- Pulse `clear` during a HOLD frame with `tvalid`=1 → `tready`=0 that cycle, `lines_out` all 0x20, `frame_err`=0, `frame_count` kept, no commit.
- Commit 256 frames → `frame_count` wraps to 0. Assert `reset` mid-frame → all outputs return to reset values at once.
